ov7670_sccb_config: RTL
=======================

// Module: ov7670_sccb_config
// PURPOSE
// - Boot-time configurator for the OV7670 camera; the camera capture interface and pixel path depend on this setup.
// - After reset, walks an internal register table and writes each entry over SCCB (3-phase write: dev addr, reg addr, data).
// - Must finish before the capture path is enabled (RGB565, VGA 640x480, PCLK free-running).
// - Drives SIOC and an open-drain SIOD (oe/out split); the top level owns the IOBUF.
// PARAMETERS
// - CLK_FREQ      100_000_000  system clock frequency, Hz
// - SCCB_FREQ     100_000      SIOC frequency, Hz; quarter-bit tick Q = CLK_FREQ/(4*SCCB_FREQ), integer, >=2
// - DEV_ADDR      8'h42        OV7670 write address (bit0=0)
// - PWRUP_CYCLES  1_000_000    clk cycles held in power-up wait before the first transaction
// - GAP_CYCLES    1_000        idle clk cycles between consecutive transactions (SIOC=1, SIOD released)
// - DELAY_CYCLES  1_000_000    clk cycles waited on a table DELAY marker (after COM7 soft reset)
// PORTS
// - clk         in   1   system clock
// - rst_n       in   1   synchronous active-low reset
// - start       in   1   1-cycle pulse: restart the table from entry 0 (ignored while busy)
// - busy        out  1   high from power-up wait through the last STOP
// - done        out  1   high once the table completes; cleared by start or reset
// - entry_idx   out  8   index of the entry being sent (debug)
// - sioc        out  1   SCCB clock
// - siod_oe     out  1   1 = drive SIOD low, 0 = release (pull-up gives 1)
// - cam_RESET   out  1   camera reset_n pin; 0 during reset and power-up wait, 1 after
// - cam_PWDN    out  1   camera power-down pin; constant 0
// BEHAVIOUR
// - Interface: one clock domain (clk); reset is synchronous and active-low (rst_n).
// - Reset values: busy=1, done=0, entry_idx=0, sioc=1, siod_oe=0, cam_RESET=0.
// - Table: internal ROM of 16-bit {reg,data} entries.
//   - 16'hFFFF = END.
//   - 16'hFFF0 = DELAY.
//   - Entry 0 = 16'h1280 (COM7 soft reset); entry 1 = DELAY.
//   - Remaining entries = RGB565/VGA set; END is mandatory.
// - FSM: PWRUP -> FETCH -> {START -> SEND -> STOP -> GAP -> FETCH | DELAY -> FETCH | END -> DONE}.
// - PWRUP: counts PWRUP_CYCLES. cam_RESET rises on entry to PWRUP+1/2 of the count; the exit goes to FETCH.
// - FETCH: 1 cycle, registered ROM read.
//   - END -> DONE: busy=0, done=1.
//   - DELAY -> counts DELAY_CYCLES, then increments idx.
// - START (2Q): SIOD low while SIOC=1 for Q, then SIOC low for Q.
// - SEND: 27 bits = 3 x (8 data MSB-first + 1 don't-care). Each bit is 4Q:
//   - q0: SIOC=0 and SIOD updated.
//   - q1, q2: SIOC=1.
//   - q3: SIOC=0.
//   - Don't-care bit: siod_oe=0, SIOD not sampled, no error path.
// - STOP (3Q): SIOD low with SIOC=0, then SIOC=1, then SIOD released. Then GAP_CYCLES, then idx+1.
// - One transaction = 2Q + 27*4Q + 3Q quarter-ticks, exact (checked by bench).
// - start while busy: ignored. start while DONE: idx=0, done=0, busy=1, go straight to FETCH (no PWRUP).
// - rst_n low mid-transaction: outputs take their reset values next edge. The bus is left released; the camera's SCCB recovers on the next START.
// - entry_idx wraps at 255 only if END is missing (a table error; the bench flags it).
// CONFIGURATION
// - OV7670_CFG_VERIFY_EN defined:
//   - After each write's GAP, perform a 2-phase write (dev, reg) then a 2-phase read (DEV_ADDR|1, 8 bits sampled at q2 with siod_oe=0, master NACK=1).
//   - Adds input siod_i and output cfg_err (sticky, cleared by start/reset) set on any readback != written data.
//   - COM7 (reg 0x12) entries are not verified.
// - OV7670_CFG_VERIFY_EN undefined: write-only; siod_i/cfg_err are absent.
// TESTING
// - Reset, CLK_FREQ=400, SCCB_FREQ=100 (Q=1): cam_RESET=0 for PWRUP/2 cycles, busy=1, sioc=1, siod_oe=0 throughout PWRUP.
// - SCCB monitor on entry 0: decodes bytes 42,12,80; each transaction = 113 quarter-ticks; next FETCH hits DELAY, with no SIOC edge for DELAY_CYCLES.
// - Full table run: byte triples match the ROM in order; after END, busy=0, done=1, sioc=1, siod_oe=0.
// - start pulse during busy: no effect. start after done: done=0 next cycle; first START occurs within 2 cycles with no PWRUP.
// - rst_n low in the middle of byte 2: next edge gives sioc=1, siod_oe=0, busy=1, idx=0; sequence restarts from PWRUP.
// - VERIFY_EN: model returns the written data except reg 0x40 returns 0x00 -> cfg_err=1 after that entry; remaining entries still written.

Source files
------------

// File: rtl/ov7670_sccb_config.sv
// ov7670_sccb_config
//   Boot-time configurator for the OV7670. After reset it holds the camera in
//   reset for half of a power-up wait, then walks an internal {reg,data}
//   table and writes each entry over SCCB. The entry 16'hFFF0 inserts a long
//   wait (used after the COM7 soft reset). The entry 16'hFFFF ends the table.
//   Optional build macro: OV7670_CFG_VERIFY_EN. It reads back every non-COM7
//   entry after writing it and raises a sticky cfg_err on any difference.
// Ports
//   clk        system clock
//   rst_n      synchronous active-low reset
//   start      1-cycle pulse, restarts the table from entry 0 (only when done)
//   busy       high from power-up wait until the table completes
//   done       high once the table completes; cleared by start or reset
//   entry_idx  index of the table entry being processed (debug)
//   sioc       SCCB clock
//   siod_oe    1 = drive SIOD low, 0 = release (external pull-up)
//   cam_RESET  camera reset_n pin
//   cam_PWDN   camera power-down pin, tied low
//   siod_i     (verify build) SIOD input from the IOBUF
//   cfg_err    (verify build) sticky readback mismatch flag
module ov7670_sccb_config #(
  parameter int         CLK_FREQ     = 100_000_000,
  parameter int         SCCB_FREQ    = 100_000,
  parameter logic [7:0] DEV_ADDR     = 8'h42,
  parameter int         PWRUP_CYCLES = 1_000_000,
  parameter int         GAP_CYCLES   = 1_000,
  parameter int         DELAY_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
`ifdef OV7670_CFG_VERIFY_EN
  input  logic       siod_i,
  output logic       cfg_err,
`endif
  output logic       busy,
  output logic       done,
  output logic [7:0] entry_idx,
  output logic       sioc,
  output logic       siod_oe,
  output logic       cam_RESET,
  output logic       cam_PWDN
);

  localparam int          Q          = CLK_FREQ / (4 * SCCB_FREQ);
  localparam logic [15:0] Q_LAST     = 16'(Q - 1);
  localparam logic [31:0] PWRUP_LAST = 32'(PWRUP_CYCLES - 1);
  localparam logic [31:0] PWRUP_HALF = 32'(PWRUP_CYCLES / 2);
  localparam logic [31:0] GAP_LAST   = 32'(GAP_CYCLES - 1);
  localparam logic [31:0] DELAY_LAST = 32'(DELAY_CYCLES - 1);
  localparam logic [15:0] TBL_END    = 16'hFFFF;
  localparam logic [15:0] TBL_DELAY  = 16'hFFF0;
  localparam logic [4:0]  BITS3_LAST = 5'd26;  // 3 bytes x 9 bits
`ifdef OV7670_CFG_VERIFY_EN
  localparam logic [4:0]  BITS2_LAST = 5'd17;  // 2 bytes x 9 bits
`endif

  typedef enum logic [2:0] {
    S_PWRUP, S_FETCH, S_START, S_SEND, S_STOP, S_GAP, S_DELAY, S_DONE
  } state_t;

`ifdef OV7670_CFG_VERIFY_EN
  typedef enum logic [1:0] {K_WRITE, K_ADDR, K_READ} kind_t;
  kind_t      kind, kind_nxt;
  logic [7:0] rd_sh;
`endif

  state_t      state, state_nxt;
  logic [15:0] qcnt;
  logic [1:0]  qph;
  logic [4:0]  bitcnt;
  logic [31:0] cnt;
  logic [26:0] shreg, shreg_load;
  logic [15:0] rom_q;
  logic [7:0]  idx_nxt;
  logic        tick, phase_end, send_last, in_bus;

  // Register table: RGB565, VGA 640x480, free-running PCLK.
  function automatic logic [15:0] rom_f(input logic [7:0] a);
    case (a)
      8'd0:    return 16'h1280;  // COM7 soft reset
      8'd1:    return TBL_DELAY;
      8'd2:    return 16'h1204;  // COM7 RGB output, VGA
      8'd3:    return 16'h1100;  // CLKRC
      8'd4:    return 16'h0C00;  // COM3
      8'd5:    return 16'h3E00;  // COM14
      8'd6:    return 16'h0400;  // COM1
      8'd7:    return 16'h8C00;  // RGB444 off
      8'd8:    return 16'h40D0;  // COM15 RGB565, full range
      8'd9:    return 16'h3A04;  // TSLB
      8'd10:   return 16'h1438;  // COM9
      8'd11:   return 16'h4FB3;  // colour matrix
      8'd12:   return 16'h50B3;
      8'd13:   return 16'h5100;
      8'd14:   return 16'h523D;
      8'd15:   return 16'h53A7;
      8'd16:   return 16'h54E4;
      8'd17:   return 16'h589E;
      8'd18:   return 16'h3DC0;  // COM13
      8'd19:   return 16'h1713;  // HSTART
      8'd20:   return 16'h1801;  // HSTOP
      8'd21:   return 16'h32B6;  // HREF
      8'd22:   return 16'h1902;  // VSTART
      8'd23:   return 16'h1A7A;  // VSTOP
      8'd24:   return 16'h030A;  // VREF
      default: return TBL_END;
    endcase
  endfunction

  assign tick   = (qcnt == Q_LAST);
  assign in_bus = (state == S_START) || (state == S_SEND) || (state == S_STOP);

  always_comb begin
    phase_end = 1'b0;
    case (state)
      S_START: phase_end = tick && (qph == 2'd1);
      S_SEND:  phase_end = tick && (qph == 2'd3);
      S_STOP:  phase_end = tick && (qph == 2'd2);
      default: phase_end = 1'b0;
    endcase
  end

`ifdef OV7670_CFG_VERIFY_EN
  assign send_last = (bitcnt == ((kind == K_WRITE) ? BITS3_LAST : BITS2_LAST));

  // Unsent tail bits are ones so the line stays released (ACK slots, read data, NACK).
  always_comb begin
    case (kind_nxt)
      K_ADDR:  shreg_load = {DEV_ADDR, 1'b1, rom_q[15:8], 1'b1, 9'h1FF};
      K_READ:  shreg_load = {DEV_ADDR | 8'h01, 1'b1, 8'hFF, 1'b1, 9'h1FF};
      default: shreg_load = {DEV_ADDR, 1'b1, rom_q[15:8], 1'b1, rom_q[7:0], 1'b1};
    endcase
  end
`else
  assign send_last  = (bitcnt == BITS3_LAST);
  assign shreg_load = {DEV_ADDR, 1'b1, rom_q[15:8], 1'b1, rom_q[7:0], 1'b1};
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_PWRUP;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    idx_nxt   = entry_idx;
`ifdef OV7670_CFG_VERIFY_EN
    kind_nxt  = kind;
`endif
    case (state)
      S_PWRUP: if (cnt == PWRUP_LAST) state_nxt = S_FETCH;
      S_FETCH: begin
        if (rom_q == TBL_END)        state_nxt = S_DONE;
        else if (rom_q == TBL_DELAY) state_nxt = S_DELAY;
        else begin
          state_nxt = S_START;
`ifdef OV7670_CFG_VERIFY_EN
          kind_nxt  = K_WRITE;
`endif
        end
      end
      S_START: if (phase_end) state_nxt = S_SEND;
      S_SEND:  if (phase_end && send_last) state_nxt = S_STOP;
      S_STOP:  if (phase_end) state_nxt = S_GAP;
      S_GAP: begin
        if (cnt == GAP_LAST) begin
`ifdef OV7670_CFG_VERIFY_EN
          if (kind == K_WRITE && rom_q[15:8] != 8'h12) begin
            state_nxt = S_START;
            kind_nxt  = K_ADDR;
          end else if (kind == K_ADDR) begin
            state_nxt = S_START;
            kind_nxt  = K_READ;
          end else begin
            state_nxt = S_FETCH;
            idx_nxt   = entry_idx + 8'd1;
          end
`else
          state_nxt = S_FETCH;
          idx_nxt   = entry_idx + 8'd1;
`endif
        end
      end
      S_DELAY: begin
        if (cnt == DELAY_LAST) begin
          state_nxt = S_FETCH;
          idx_nxt   = entry_idx + 8'd1;
        end
      end
      S_DONE: begin
        if (start) begin
          state_nxt = S_FETCH;
          idx_nxt   = 8'd0;
        end
      end
      default: state_nxt = S_PWRUP;
    endcase
  end

  // Datapath. The ROM is addressed with the next index so that rom_q already
  // holds the current entry during the single FETCH cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      entry_idx <= '0;
      rom_q     <= rom_f(8'd0);
      cnt       <= '0;
      qcnt      <= '0;
      qph       <= '0;
      bitcnt    <= '0;
      shreg     <= '1;
      cam_RESET <= 1'b0;
`ifdef OV7670_CFG_VERIFY_EN
      kind      <= K_WRITE;
      rd_sh     <= '0;
      cfg_err   <= 1'b0;
`endif
    end else begin
      entry_idx <= idx_nxt;
      rom_q     <= rom_f(idx_nxt);
      cnt       <= (state_nxt != state) ? '0 : cnt + 32'd1;
      if (state == S_PWRUP && cnt == PWRUP_HALF) cam_RESET <= 1'b1;

      if (!in_bus)   qcnt <= '0;
      else           qcnt <= tick ? '0 : qcnt + 16'd1;
      if (!in_bus)   qph <= '0;
      else if (tick) qph <= phase_end ? 2'd0 : qph + 2'd1;

      if (state != S_SEND) bitcnt <= '0;
      else if (phase_end)  bitcnt <= bitcnt + 5'd1;

      if (state_nxt == S_START && state != S_START) shreg <= shreg_load;
      else if (state == S_SEND && phase_end)        shreg <= {shreg[25:0], 1'b1};
`ifdef OV7670_CFG_VERIFY_EN
      kind <= kind_nxt;
      if (state == S_SEND && kind == K_READ && tick && qph == 2'd2 &&
          bitcnt >= 5'd9 && bitcnt <= 5'd16)
        rd_sh <= {rd_sh[6:0], siod_i};
      if (state == S_DONE && start)
        cfg_err <= 1'b0;
      else if (state == S_STOP && phase_end && kind == K_READ && rd_sh != rom_q[7:0])
        cfg_err <= 1'b1;
`endif
    end
  end

  // Outputs
  always_comb begin
    sioc     = 1'b1;
    siod_oe  = 1'b0;
    busy     = (state != S_DONE);
    done     = (state == S_DONE);
    cam_PWDN = 1'b0;
    case (state)
      S_START: begin
        siod_oe = 1'b1;
        sioc    = (qph == 2'd0);
      end
      S_SEND: begin
        sioc    = (qph == 2'd1) || (qph == 2'd2);
        siod_oe = ~shreg[26];
      end
      S_STOP: begin
        sioc    = (qph != 2'd0);
        siod_oe = (qph != 2'd2);
      end
      default: ;
    endcase
  end

endmodule
